// File: rtl/spi_pwm_timer.sv
// PWM/timer peripheral driven from the SPI register bank.
// cfg0: EN/ONESHOT/INV/CLR/PSC, cfg1-2: PERIOD, cfg3-4: DUTY, cfg5: irq masks.
// stat0-1: counter, stat2: flags, stat3: wrap count, stat4: ID, stat5: version.
// NUM_CFG must be at least 6, NUM_STATUS must equal NUM_CFG, REG_WIDTH must be 8.
module spi_pwm_timer #(
  parameter int unsigned NUM_CFG    = 8,
  parameter int unsigned NUM_STATUS = 8,
  parameter int unsigned REG_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  input  logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  output logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic                            pwm_out,
  output logic                            irq
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Config field decode
  logic        cfg_en;
  logic        cfg_oneshot;
  logic        cfg_inv;
  logic        cfg_clr;
  logic [3:0]  cfg_psc;
  logic [15:0] cfg_period;
  logic [15:0] cfg_duty;
  logic        cfg_mask_wrap;
  logic        cfg_mask_cmp;

  assign cfg_en        = config_regs[0];
  assign cfg_oneshot   = config_regs[1];
  assign cfg_inv       = config_regs[2];
  assign cfg_clr       = config_regs[3];
  assign cfg_psc       = config_regs[7:4];
  assign cfg_period    = config_regs[23:8];
  assign cfg_duty      = config_regs[39:24];
  assign cfg_mask_wrap = config_regs[40];
  assign cfg_mask_cmp  = config_regs[41];

  // Reserved config bits are deliberately ignored.
  logic unused_cfg;
  if (NUM_CFG > 6) begin : g_unused_wide
    assign unused_cfg = ^{config_regs[47:42], config_regs[NUM_CFG*REG_WIDTH-1:48]};
  end else begin : g_unused_min
    assign unused_cfg = ^config_regs[47:42];
  end

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] psc_q, psc_d;
  logic [15:0] period_s_q, period_s_d;
  logic [15:0] duty_s_q, duty_s_d;
  logic        wrap_q, wrap_d;
  logic        cmp_q, cmp_d;
  logic        done_q, done_d;
  logic [7:0]  wrap_cnt_q, wrap_cnt_d;
  logic        pwm_q, pwm_d;
  logic        irq_q, irq_d;
  logic        clr_prev_q, clr_prev_d;

  logic        running;
  logic        clr_edge;
  logic        tick;
  logic [15:0] psc_lim;
  logic [15:0] cnt_inc;

  assign running  = (state_q == StRun);
  assign clr_edge = cfg_clr & ~clr_prev_q;
  assign psc_lim  = (16'd1 << cfg_psc) - 16'd1;
  assign cnt_inc  = cnt_q + 16'd1;

  // Next-state logic for the FSM, counter, prescaler, shadows and flags
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    psc_d      = psc_q;
    period_s_d = period_s_q;
    duty_s_d   = duty_s_q;
    wrap_d     = wrap_q;
    cmp_d      = cmp_q;
    done_d     = done_q;
    wrap_cnt_d = wrap_cnt_q;
    clr_prev_d = cfg_clr;
    tick       = 1'b0;

    // pwm_out lags the counter by one cycle; outside RUN it rests at INV.
    pwm_d = (running && (cnt_q < duty_s_q)) ^ cfg_inv;
    irq_d = (wrap_q & cfg_mask_wrap) | (cmp_q & cfg_mask_cmp);

    // Shadows track config whenever the timer is not running.
    if (!running) begin
      period_s_d = cfg_period;
      duty_s_d   = cfg_duty;
    end

    if (clr_edge) begin
      wrap_d     = 1'b0;
      cmp_d      = 1'b0;
      done_d     = 1'b0;
      wrap_cnt_d = 8'd0;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = 16'd0;
        psc_d = 16'd0;
        if (cfg_en) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!cfg_en) begin
          state_d = StIdle;
          cnt_d   = 16'd0;
          psc_d   = 16'd0;
        end else if (clr_edge) begin
          // CLR wins over any wrap or compare landing in the same cycle.
          cnt_d = 16'd0;
          psc_d = 16'd0;
        end else begin
          if (psc_q == psc_lim) begin
            psc_d = 16'd0;
            tick  = 1'b1;
          end else begin
            psc_d = psc_q + 16'd1;
          end
          // A zero period parks the counter at 0 with no events.
          if (tick && (period_s_q != 16'd0)) begin
            if (cnt_q == period_s_q) begin
              cnt_d      = 16'd0;
              wrap_d     = 1'b1;
              wrap_cnt_d = wrap_cnt_q + 8'd1;
              period_s_d = cfg_period;
              duty_s_d   = cfg_duty;
              if (cfg_oneshot) begin
                state_d = StDone;
                done_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc == duty_s_q) begin
                cmp_d = 1'b1;
              end
            end
          end
        end
      end
      StDone: begin
        cnt_d = 16'd0;
        psc_d = 16'd0;
        if (!cfg_en || clr_edge) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 16'd0;
        psc_d   = 16'd0;
      end
    endcase
  end

  // State registers; ena low freezes everything including the CLR edge detector
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= StIdle;
      cnt_q      <= 16'd0;
      psc_q      <= 16'd0;
      period_s_q <= 16'd0;
      duty_s_q   <= 16'd0;
      wrap_q     <= 1'b0;
      cmp_q      <= 1'b0;
      done_q     <= 1'b0;
      wrap_cnt_q <= 8'd0;
      pwm_q      <= 1'b0;
      irq_q      <= 1'b0;
      clr_prev_q <= 1'b0;
    end else if (ena) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      psc_q      <= psc_d;
      period_s_q <= period_s_d;
      duty_s_q   <= duty_s_d;
      wrap_q     <= wrap_d;
      cmp_q      <= cmp_d;
      done_q     <= done_d;
      wrap_cnt_q <= wrap_cnt_d;
      pwm_q      <= pwm_d;
      irq_q      <= irq_d;
      clr_prev_q <= clr_prev_d;
    end
  end

  // Status bank; counter bytes are live, so multi-byte reads may tear
  always_comb begin
    status_regs        = '0;
    status_regs[15:0]  = cnt_q;
    status_regs[23:16] = {3'b000, done_q, pwm_q, running, cmp_q, wrap_q};
    status_regs[31:24] = wrap_cnt_q;
    status_regs[39:32] = 8'hC5;
    status_regs[47:40] = 8'h01;
  end

  assign pwm_out = pwm_q;
  assign irq     = irq_q;

endmodule
